// File: rtl/mux_scan_nch.sv
// N-channel registered mux: manual select or auto-scan over masked channels
// with a programmable dwell per channel. All outputs are registered.
module mux_scan_nch #(
  parameter  int N_CH  = 4,
  parameter  int DW    = 1,
  parameter  int DWELL = 1,
  localparam int SELW  = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [N_CH*DW-1:0] din,
  output logic [DW-1:0]      y,
  output logic [SELW-1:0]    y_ch,
  output logic               y_valid,
  output logic               wrap
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MANUAL = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;

  logic [1:0]      state, state_nxt;
  logic [SELW-1:0] ptr, ptr_nxt;
  logic [CW-1:0]   dwell_cnt, cnt_cur;
  logic            ptr_hit, sel_hit, any_mask, found;
  logic [DW-1:0]   ptr_data, sel_data;
  int unsigned     idx;

  always_comb begin
    state_nxt = !en ? S_IDLE : (mode ? S_SCAN : S_MANUAL);
    // Entering scan always starts a fresh dwell on the retained pointer
    cnt_cur   = (state == S_SCAN) ? dwell_cnt : '0;
    any_mask  = |ch_mask;
    ptr_hit   = 1'b0;
    ptr_data  = '0;
    sel_hit   = 1'b0;
    sel_data  = '0;
    // Loop-based selection keeps out-of-range selects from indexing past din/ch_mask
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (SELW'(i) == ptr) begin
        ptr_hit  = ch_mask[i];
        ptr_data = din[i*DW +: DW];
      end
      if (SELW'(i) == sel) begin
        sel_hit  = ch_mask[i];
        sel_data = din[i*DW +: DW];
      end
    end
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      idx = (32'(ptr) + k) % unsigned'(N_CH);
      if (!found && ch_mask[idx]) begin
        ptr_nxt = SELW'(idx);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      dwell_cnt <= '0;
      y         <= '0;
      y_ch      <= '0;
      y_valid   <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state_nxt)
        S_MANUAL: begin
          y_ch      <= sel;
          y         <= sel_hit ? sel_data : '0;
          y_valid   <= sel_hit;
          wrap      <= 1'b0;
          dwell_cnt <= '0;
        end
        S_SCAN: begin
          if (!any_mask) begin
            y         <= '0;
            y_valid   <= 1'b0;
            wrap      <= 1'b0;
            dwell_cnt <= '0;
          end else if (ptr_hit) begin
            y       <= ptr_data;
            y_ch    <= ptr;
            y_valid <= 1'b1;
            if (cnt_cur == CW'(DWELL - 1)) begin
              ptr       <= ptr_nxt;
              dwell_cnt <= '0;
              wrap      <= (ptr_nxt <= ptr);
            end else begin
              dwell_cnt <= cnt_cur + CW'(1);
              wrap      <= 1'b0;
            end
          end else begin
            y         <= '0;
            y_valid   <= 1'b0;
            ptr       <= ptr_nxt;
            dwell_cnt <= '0;
            wrap      <= (ptr_nxt <= ptr);
          end
        end
        default: begin
          y         <= '0;
          y_valid   <= 1'b0;
          wrap      <= 1'b0;
          dwell_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_nch.sv
// Bench for mux_scan_nch: two configurations (4ch/4b/dwell2, 5ch/8b/dwell1)
// checked every cycle against a behavioural model plus directed constants.
module tb_mux_scan_nch;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic        en_a, mode_a;
  logic [1:0]  sel_a;
  logic [3:0]  mask_a;
  logic [15:0] din_a;
  logic [3:0]  y_a;
  logic [1:0]  ych_a;
  logic        yv_a, wr_a;

  logic        en_b, mode_b;
  logic [2:0]  sel_b;
  logic [4:0]  mask_b;
  logic [39:0] din_b;
  logic [7:0]  y_b;
  logic [2:0]  ych_b;
  logic        yv_b, wr_b;

  mux_scan_nch #(.N_CH(4), .DW(4), .DWELL(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .sel(sel_a),
    .ch_mask(mask_a), .din(din_a), .y(y_a), .y_ch(ych_a),
    .y_valid(yv_a), .wrap(wr_a)
  );

  mux_scan_nch #(.N_CH(5), .DW(8), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .sel(sel_b),
    .ch_mask(mask_b), .din(din_b), .y(y_b), .y_ch(ych_b),
    .y_valid(yv_b), .wrap(wr_b)
  );

  int n_vec = 0;
  int n_err = 0;

  int          pa, ca, pb, cb;
  logic [63:0] eya, echa, eyb, echb;
  logic        eva, ewa, evb, ewb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: ptr/cnt are plain integers, next channel found by
  // a circular search over the mask.
  task automatic model(input int nch, input int dw, input int dwell,
                       input logic en, input logic mode, input int sel,
                       input logic [63:0] mask, input logic [63:0] din,
                       inout int ptr, inout int cnt,
                       inout logic [63:0] ey, inout logic [63:0] ech,
                       inout logic ev, inout logic ew);
    int nxt;
    logic [63:0] fm;
    fm = (64'd1 << dw) - 64'd1;
    if (!en) begin
      ey = 0; ev = 0; ew = 0; cnt = 0;
    end else if (!mode) begin
      ech = sel;
      ev  = (sel < nch) && mask[sel];
      ey  = ev ? ((din >> (sel*dw)) & fm) : 64'd0;
      ew  = 0; cnt = 0;
    end else if (mask == 0) begin
      ey = 0; ev = 0; ew = 0; cnt = 0;
    end else begin
      nxt = ptr;
      for (int k = nch; k >= 1; k--)
        if (mask[(ptr+k)%nch]) nxt = (ptr+k)%nch;
      if (mask[ptr]) begin
        ey = (din >> (ptr*dw)) & fm; ech = ptr; ev = 1;
        cnt++;
        if (cnt == dwell) begin
          cnt = 0; ew = (nxt <= ptr); ptr = nxt;
        end else ew = 0;
      end else begin
        ey = 0; ev = 0; ew = (nxt <= ptr); ptr = nxt; cnt = 0;
      end
    end
  endtask

  task automatic mreset();
    pa = 0; ca = 0; eya = 0; echa = 0; eva = 0; ewa = 0;
    pb = 0; cb = 0; eyb = 0; echb = 0; evb = 0; ewb = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) mreset();
    else begin
      model(4, 4, 2, en_a, mode_a, int'(sel_a), 64'(mask_a), 64'(din_a),
            pa, ca, eya, echa, eva, ewa);
      model(5, 8, 1, en_b, mode_b, int'(sel_b), 64'(mask_b), 64'(din_b),
            pb, cb, eyb, echb, evb, ewb);
    end
    #1;
    chk("a_y", 64'(y_a), eya);   chk("a_ych", 64'(ych_a), echa);
    chk("a_valid", 64'(yv_a), 64'(eva)); chk("a_wrap", 64'(wr_a), 64'(ewa));
    chk("b_y", 64'(y_b), eyb);   chk("b_ych", 64'(ych_b), echb);
    chk("b_valid", 64'(yv_b), 64'(evb)); chk("b_wrap", 64'(wr_b), 64'(ewb));
  endtask

  task automatic rnd_b();
    din_b = 40'({$urandom(), $urandom()});
  endtask

  logic [3:0] t2_exp [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
  int         t3_seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  logic       reached;

  initial begin
    en_a = 1; mode_a = 1; sel_a = 2'($urandom); mask_a = 4'($urandom); din_a = 16'($urandom);
    en_b = 1; mode_b = 1; sel_b = 0; mask_b = 5'h1F; rnd_b();
    mreset();

    // reset held with arbitrary inputs
    #2 rst_n = 1'b0;
    #1;
    chk("rst_y", 64'(y_a), 0); chk("rst_valid", 64'(yv_a), 0); chk("rst_wrap", 64'(wr_a), 0);
    repeat (3) begin
      din_a = 16'($urandom); mask_a = 4'($urandom); rnd_b();
      cyc();
    end
    rst_n = 1'b1;

    // manual select
    mode_a = 0; mask_a = 4'hF; din_a = 16'hDCBA;
    for (int s = 0; s < 4; s++) begin
      sel_a = 2'(s); rnd_b();
      cyc();
      chk("t2_y_const", 64'(y_a), 64'(t2_exp[s]));
    end
    mask_a = 4'b1011; sel_a = 2'd2; rnd_b();
    cyc();
    chk("t2_masked_y", 64'(y_a), 0); chk("t2_masked_valid", 64'(yv_a), 0);

    // scan, full mask
    mode_a = 1; mask_a = 4'hF;
    for (int i = 0; i < 9; i++) begin
      din_a = 16'($urandom); rnd_b();
      cyc();
      chk("t3_ych_seq", 64'(ych_a), 64'(t3_seq[i]));
    end
    repeat (4) begin din_a = 16'($urandom); rnd_b(); cyc(); end

    // asynchronous reset mid-scan
    #2 rst_n = 1'b0;
    #1;
    mreset();
    chk("arst_y", 64'(y_a), 0); chk("arst_valid", 64'(yv_a), 0);
    chk("arst_ych", 64'(ych_a), 0); chk("arst_wrap", 64'(wr_a), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (3) begin din_a = 16'($urandom); rnd_b(); cyc(); end

    // masked scans
    mask_a = 4'b1010; repeat (8) begin din_a = 16'($urandom); rnd_b(); cyc(); end
    mask_a = 4'b0000; repeat (4) begin din_a = 16'($urandom); rnd_b(); cyc(); end
    mask_a = 4'b0100; repeat (6) begin din_a = 16'($urandom); rnd_b(); cyc(); end

    // enable toggle mid-dwell on channel 1
    mask_a = 4'hF;
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      din_a = 16'($urandom); rnd_b();
      cyc();
      reached = (pa == 1 && ca == 1);
    end
    chk("t5_reach_ch1", 64'(reached), 1);
    en_a = 0; repeat (2) begin din_a = 16'($urandom); cyc(); end
    en_a = 1; repeat (4) begin din_a = 16'($urandom); cyc(); end

    // out-of-range manual selects on the 5-channel instance
    mode_b = 0;
    for (int s = 5; s < 8; s++) begin
      sel_b = 3'(s); rnd_b();
      cyc();
      chk("t6_oor_valid", 64'(yv_b), 0);
    end

    // randomized traffic
    repeat (400) begin
      en_a = ($urandom_range(0, 7) != 0); mode_a = 1'($urandom);
      sel_a = 2'($urandom); din_a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) mask_a = 4'($urandom);
      en_b = ($urandom_range(0, 7) != 0); mode_b = ($urandom_range(0, 3) != 0);
      sel_b = 3'($urandom); rnd_b();
      if ($urandom_range(0, 3) == 0) mask_b = 5'($urandom);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
